// File: rtl/inv_montgomery_mode_if.sv
// Request/result bundle for the modular inverter.
// The slave modport is the inverter side; the master modport is the requester side.
interface inv_montgomery_mode_if #(
   parameter int N  = 255,
   parameter int KW = $clog2(2*N+2)
);
   // Both directions use valid/ready. A request transfers on a rising edge
   // where req_valid & req_ready are high. A result transfers on a rising edge
   // where res_valid & res_ready are high. The data on each side stays stable
   // while its valid is high and ready is low.
   logic          req_valid;
   logic          req_ready;
   logic [N-1:0]  X;
   logic [N-1:0]  M;
   logic [1:0]    mode;
   logic          busy;
   logic          res_valid;
   logic          res_ready;
   logic [N-1:0]  R;
   logic [KW-1:0] k_out;
   logic          err;

   modport slave (
      input  req_valid, X, M, mode, res_ready,
      output req_ready, busy, res_valid, R, k_out, err
   );

   modport master (
      output req_valid, X, M, mode, res_ready,
      input  req_ready, busy, res_valid, R, k_out, err
   );
endinterface

// File: rtl/inv_montgomery_mode.sv
// Kaliski almost-inverse followed by a mode-selected halve/double correction.
// Define INV_MONT_RADIX4_EN to run two correction steps per PH2 cycle.
module inv_montgomery_mode #(
   parameter int N  = 255,
   parameter int KW = $clog2(2*N+2)
) (
   input  logic                       clk,
   input  logic                       rst,
   inv_montgomery_mode_if.slave       bus,
   output logic [2:0]                 dbg_state
);
   typedef enum logic [2:0] {IDLE, CHECK, PH1, CORR, PH2, DONE} state_t;

   state_t        state, state_n;
   logic [N-1:0]  x_q, m_q, u, v, r_out;
   logic [1:0]    mode_q;
   logic [N:0]    r, s, m_ext, r_p;
   logic [KW-1:0] k, cnt, t, k_out_q;
   logic          halve_q, err_q, bad;

   assign m_ext = {1'b0, m_q};
   assign bad   = ~m_q[0] | (m_q < N'(3)) | (x_q == '0) | (x_q >= m_q) | (mode_q == 2'd3);
   assign t     = (mode_q == 2'd0) ? '0 : (mode_q == 2'd1) ? KW'(N) : k;
   assign r_p   = (r >= m_ext) ? r - m_ext : r;

   // Both steps keep r inside [0, M); all sums fit the N+1-bit lane.
   function automatic logic [N:0] halve_m(input logic [N:0] a, input logic [N:0] m);
      logic [N:0] sum;
      sum = a[0] ? a + m : a;
      return sum >> 1;
   endfunction

   function automatic logic [N:0] double_m(input logic [N:0] a, input logic [N:0] m);
      logic [N:0] d;
      d = a << 1;
      return (d >= m) ? d - m : d;
   endfunction

   function automatic logic [N:0] step_m(input logic [N:0] a, input logic [N:0] m, input logic h);
      return h ? halve_m(a, m) : double_m(a, m);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (bus.req_valid) state_n = CHECK;
         CHECK:   state_n = bad ? DONE : PH1;
         PH1:     if (v == '0) state_n = (u == N'(1)) ? CORR : DONE;
         CORR:    state_n = PH2;
         PH2:     if (cnt == '0) state_n = DONE;
         DONE:    if (bus.res_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q <= '0; m_q <= '0; mode_q <= '0;
         u <= '0; v <= '0; r <= '0; s <= '0;
         k <= '0; cnt <= '0; halve_q <= 1'b0;
         r_out <= '0; k_out_q <= '0; err_q <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.req_valid) begin
               x_q    <= bus.X;
               m_q    <= bus.M;
               mode_q <= bus.mode;
            end
            CHECK: if (bad) begin
               r_out <= '0; k_out_q <= '0; err_q <= 1'b1;
            end else begin
               u <= m_q; v <= x_q; r <= '0; s <= (N+1)'(1); k <= '0;
            end
            PH1: if (v != '0) begin
               k <= k + KW'(1);
               if (!u[0]) begin
                  u <= u >> 1; s <= s << 1;
               end else if (!v[0]) begin
                  v <= v >> 1; r <= r << 1;
               end else if (u > v) begin
                  u <= (u - v) >> 1; r <= r + s; s <= s << 1;
               end else begin
                  v <= (v - u) >> 1; s <= s + r; r <= r << 1;
               end
            end else if (u != N'(1)) begin
               r_out <= '0; k_out_q <= k; err_q <= 1'b1;
            end
            CORR: begin
               r       <= (r_p == '0) ? '0 : m_ext - r_p;
               halve_q <= (k > t);
               cnt     <= (k > t) ? k - t : t - k;
            end
            PH2: if (cnt != '0) begin
`ifdef INV_MONT_RADIX4_EN
               if (cnt >= KW'(2)) begin
                  r   <= step_m(step_m(r, m_ext, halve_q), m_ext, halve_q);
                  cnt <= cnt - KW'(2);
               end else begin
                  r   <= step_m(r, m_ext, halve_q);
                  cnt <= cnt - KW'(1);
               end
`else
               r   <= step_m(r, m_ext, halve_q);
               cnt <= cnt - KW'(1);
`endif
            end else begin
               r_out <= r[N-1:0]; k_out_q <= k; err_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready = (state == IDLE);
   assign bus.busy      = (state != IDLE);
   assign bus.res_valid = (state == DONE);
   assign bus.R         = r_out;
   assign bus.k_out     = k_out_q;
   assign bus.err       = err_q;
   assign dbg_state     = state;
endmodule

// File: tb/tb_inv_montgomery_mode.sv
// Directed and random checks of inv_montgomery_mode at N=8, plus one N=255 run.
module tb_inv_montgomery_mode;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [2:0] dbg8, dbg255;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   inv_montgomery_mode_if #(.N(8))   bus8 ();
   inv_montgomery_mode_if #(.N(255)) bus255 ();

   inv_montgomery_mode #(.N(8))   u_dut8   (.clk(clk), .rst(rst), .bus(bus8),   .dbg_state(dbg8));
   inv_montgomery_mode #(.N(255)) u_dut255 (.clk(clk), .rst(rst), .bus(bus255), .dbg_state(dbg255));

   typedef struct packed {
      logic [1:0] mode;
      logic [7:0] x;
      logic [7:0] m;
      logic       err;
      logic       chk_err;
      logic [7:0] r;
   } exp_t;
   exp_t exp_q[$];

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic int gcd(input int a, input int b);
      int tmp;
      while (b != 0) begin tmp = a % b; a = b; b = tmp; end
      return a;
   endfunction

   function automatic int ref_inv(input int x, input int m);
      for (int i = 1; i < m; i++) if ((i * x) % m == 1) return i;
      return 0;
   endfunction

   function automatic int pow2mod(input int k, input int m);
      int p = 1 % m;
      for (int i = 0; i < k; i++) p = (p * 2) % m;
      return p;
   endfunction

   function automatic int bitlen(input int m);
      int n = 0;
      while (m != 0) begin n++; m = m >> 1; end
      return n;
   endfunction

   task automatic push_exp(input int x, input int m, input int mode);
      exp_t e;
      e.mode    = 2'(mode);
      e.x       = 8'(x);
      e.m       = 8'(m);
      e.chk_err = (m % 2 == 0) || (m < 3) || (x == 0) || (x >= m) || (mode == 3);
      e.err     = e.chk_err || (gcd(x, m) != 1);
      e.r       = '0;
      if (!e.err && mode == 0) e.r = 8'(ref_inv(x, m));
      if (!e.err && mode == 1) e.r = 8'((ref_inv(x, m) * 256) % m);
      exp_q.push_back(e);
   endtask

   task automatic run_req(input int x, input int m, input int mode, input int hold);
      exp_t e;
      int n, kk, rr;
      @(negedge clk);
      bus8.X = 8'(x); bus8.M = 8'(m); bus8.mode = 2'(mode); bus8.req_valid = 1'b1;
      push_exp(x, m, mode);
      @(negedge clk);
      bus8.req_valid = 1'b0;
      chk("busy_rise", bus8.busy, 1);
      chk("req_ready_fall", bus8.req_ready, 0);
      n = 0;
      while (!bus8.res_valid && n < 2000) begin @(negedge clk); n++; end
      chk("res_timeout", bus8.res_valid, 1);
      e = exp_q.pop_front();
      if (!bus8.res_valid) return;
      kk = int'(bus8.k_out);
      rr = int'(bus8.R);
      chk("err", bus8.err, e.err);
      if (e.err) begin
         chk("r_err", bus8.R, 0);
         if (e.chk_err) chk("k_err", bus8.k_out, 0);
      end else begin
         chk("k_range", (kk >= bitlen(m)) && (kk <= 2 * bitlen(m)), 1);
         if (e.mode == 2'd2) begin
            chk("r2_lt_m", rr < m, 1);
            chk("r2_prop", (rr * x) % m, pow2mod(kk, m));
         end else begin
            chk("r", bus8.R, e.r);
         end
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", bus8.res_valid, 1);
         chk("hold_req_ready", bus8.req_ready, 0);
         chk("hold_r", bus8.R, e.r);
         chk("hold_err", bus8.err, e.err);
      end
      bus8.res_ready = 1'b1;
      @(negedge clk);
      bus8.res_ready = 1'b0;
      chk("handoff_valid", bus8.res_valid, 0);
      chk("handoff_busy", bus8.busy, 0);
      chk("handoff_req_ready", bus8.req_ready, 1);
   endtask

   initial begin : stim
      logic [254:0] p;
      logic [511:0] prod;
      int n, m, x, md;
      bus8.req_valid = 1'b0; bus8.res_ready = 1'b0;
      bus8.X = '0; bus8.M = '0; bus8.mode = '0;
      bus255.req_valid = 1'b0; bus255.res_ready = 1'b0;
      bus255.X = '0; bus255.M = '0; bus255.mode = '0;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_req_ready", bus8.req_ready, 1);
      chk("rst_busy", bus8.busy, 0);
      chk("rst_res_valid", bus8.res_valid, 0);
      chk("rst_err", bus8.err, 0);
      chk("rst_r", bus8.R, 0);
      chk("rst_k", bus8.k_out, 0);

      run_req(3, 13, 0, 0);
      run_req(3, 13, 1, 0);
      run_req(2, 251, 2, 0);
      run_req(5, 12, 0, 0);
      run_req(0, 13, 0, 0);
      run_req(13, 13, 0, 0);
      run_req(3, 13, 3, 0);
      run_req(5, 15, 0, 0);
      run_req(3, 13, 0, 10);
      run_req(7, 251, 1, 0);

      for (int i = 0; i < 10; i++) begin
         m  = $urandom_range(127, 1) * 2 + 1;
         x  = $urandom_range(m - 1, 1);
         md = $urandom_range(2, 0);
         run_req(x, m, md, 0);
      end

      // Abort a long run partway through phase 1.
      @(negedge clk);
      bus8.X = 8'd2; bus8.M = 8'd251; bus8.mode = 2'd0; bus8.req_valid = 1'b1;
      @(negedge clk);
      bus8.req_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_res_valid", bus8.res_valid, 0);
      chk("midrst_busy", bus8.busy, 0);
      chk("midrst_req_ready", bus8.req_ready, 1);
      rst = 1'b0;
      run_req(3, 13, 0, 0);

      p = {255{1'b1}} - 255'd18;
      @(negedge clk);
      bus255.X = 255'd9; bus255.M = p; bus255.mode = 2'd0; bus255.req_valid = 1'b1;
      @(negedge clk);
      bus255.req_valid = 1'b0;
      n = 0;
      while (!bus255.res_valid && n < 4000) begin @(negedge clk); n++; end
      chk("w_timeout", bus255.res_valid, 1);
      chk("w_err", bus255.err, 0);
      chk("w_r_lt_m", bus255.R < p, 1);
      prod = {257'd0, bus255.R} * 512'd9;
      chk("w_inv", prod % {257'd0, p}, 1);
      chk("w_k_bound", bus255.k_out <= 9'd510, 1);
      bus255.res_ready = 1'b1;
      @(negedge clk);
      bus255.res_ready = 1'b0;
      chk("w_handoff", bus255.res_valid, 0);

      chk("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
